edge_detect_multi: RTL and testbench
====================================

Name: edge_detect_multi

Overview:
- Parametrised multi-channel successor to the single-line USB edge detector.
- Each channel is synchronised and glitch-filtered.
- Each channel emits one-cycle pulses on rising and falling transitions of its filtered level, selected per channel by a mode field.
- Sits between the raw bus pins (d_plus, d_minus, auxiliary status lines) and the receive-side decoders/timers.

Parameters:
- NUM_CH, 2, number of independent input channels (>=1)
- SYNC_STAGES, 2, synchroniser depth per channel (>=2)
- FILT_LEN, 1, consecutive sync-output cycles a new value must hold before acceptance (>=1; 1 = no filtering)
- IDLE_VAL, 1, reset value of all synchroniser, filter and level flops (USB idle J on d_plus)
- CNT_W, 8, edge-counter width, used only with the optional feature

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  output qualifier; 0 forces d_edge/d_rise/d_fall to 0, pipeline keeps tracking
- d_in  in  NUM_CH  raw asynchronous channel inputs
- mode  in  2*NUM_CH  per-channel select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- d_level  out  NUM_CH  filtered, registered level per channel
- d_rise  out  NUM_CH  one-cycle pulse, qualified rising edge
- d_fall  out  NUM_CH  one-cycle pulse, qualified falling edge
- d_edge  out  NUM_CH  d_rise | d_fall
- cnt_clr  in  1  synchronous clear of all edge counters
- edge_cnt  out  CNT_W*NUM_CH  per-channel saturating edge count; channel i at [CNT_W*i +: CNT_W]

Behaviour:
- Reset (rst=1, asynchronous):
  - sync chains, filt and d_level = IDLE_VAL on all channels.
  - Filter counters = 0.
  - d_rise, d_fall, d_edge = 0.
  - edge_cnt = 0.
  - Reset asserted mid-transition discards any pending filter count; no pulse is generated by reset deassertion.
- Synchroniser: SYNC_STAGES flops per channel; s = last stage.
- Filter, per channel, counter width $clog2(FILT_LEN+1):
  - If s == filt: counter cleared.
  - If s != filt and counter == FILT_LEN-1: filt <= s, counter cleared (accept).
  - Otherwise counter increments.
  - A glitch shorter than FILT_LEN cycles at s never changes filt; a bounce back resets the count.
- Edge generation: registered at the same clock edge filt updates.
  - d_rise[i] = en & mode[2i] & (filt 0->1)
  - d_fall[i] = en & mode[2i+1] & (filt 1->0)
  - Pulse width exactly 1 cycle. Back-to-back opposite edges are separated by at least FILT_LEN cycles.
- Latency: d_in change setup before rising edge k -> d_edge high after edge k+SYNC_STAGES+FILT_LEN-1. With defaults: pulse visible 3 cycles after the input changes.
- d_level = filt at all times, regardless of en/mode.
- mode/en are sampled at the accept edge. A mode change while a filter count is pending applies to that pending edge. mode=00 still updates d_level.
- Channels are fully independent. Simultaneous edges on several channels each pulse in the same cycle.

Optional Feature:
- Macro: EDGE_CNT_EN.
- With the macro defined:
  - Each channel has a CNT_W-bit counter that increments on every d_edge[i] pulse and saturates at all-ones.
  - cnt_clr=1 zeroes all counters on the next edge. cnt_clr takes priority over a simultaneous increment (result 0).
- Without the macro: the counter logic is absent, edge_cnt is tied to 0 and cnt_clr is ignored. Port list is unchanged.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with d_in=2'b00, release -> d_level=2'b11 until filtering completes, then 2'b00. No pulse on the reset release. d_fall[1:0] pulse once each, since mode=11 and filt leaves IDLE_VAL.
- Rise latency: defaults, mode=4'b0101, d_in[0] 0->1 before edge k -> d_rise[0]=1 only during the cycle after edge k+2. d_fall, d_edge[1] stay 0.
- Glitch reject: FILT_LEN=4, d_in[1] high for 3 cycles then low -> d_level[1] unchanged, no pulse. High for 4 cycles -> single d_rise[1], d_level[1]=1.
- Mode/en gating: mode[1:0]=2'b01, falling edge -> no d_fall[0], but d_level[0]=0. Then en=0 with mode=11 on a rise -> no pulse, d_level[0]=1.
- Reset mid-operation: assert rst while FILT_LEN=4 count is at 2 -> outputs return to IDLE_VAL/0 immediately (asynchronous) and no pulse follows deassertion.
- Counter (EDGE_CNT_EN): 300 edges on ch0 with CNT_W=8 -> edge_cnt[7:0]=8'hFF. cnt_clr coincident with an edge -> 0.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronise / glitch-filter / edge-pulse block for bus pins.
// Optional per-channel saturating edge counters are built when EDGE_CNT_EN is defined.
module edge_detect_multi #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 1,
  parameter int IDLE_VAL    = 1,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       d_in,
  input  logic [2*NUM_CH-1:0]     mode,
  output logic [NUM_CH-1:0]       d_level,
  output logic [NUM_CH-1:0]       d_rise,
  output logic [NUM_CH-1:0]       d_fall,
  output logic [NUM_CH-1:0]       d_edge,
  input  logic                    cnt_clr,
  output logic [CNT_W*NUM_CH-1:0] edge_cnt
);

  localparam int              FCW    = $clog2(FILT_LEN + 1);
  localparam logic [FCW-1:0]  F_LAST = FCW'(FILT_LEN - 1);
  localparam logic            IDLE_B = (IDLE_VAL != 0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCW-1:0]         fcnt_q, fcnt_d;
    logic                   filt_q, filt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;
    logic                   accept;

    // Stage 0 is the LSB; the MSB is the synchronised sample fed to the filter.
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      fcnt_d = '0;
      filt_d = filt_q;
      accept = 1'b0;
      if (s != filt_q) begin
        if (fcnt_q == F_LAST) begin
          accept = 1'b1;
          filt_d = s;
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      rise_d = en & mode[2*i]   & accept & s;
      fall_d = en & mode[2*i+1] & accept & ~s;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{IDLE_B}};
        fcnt_q <= '0;
        filt_q <= IDLE_B;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], d_in[i]};
        fcnt_q <= fcnt_d;
        filt_q <= filt_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign d_level[i] = filt_q;
    assign d_rise[i]  = rise_q;
    assign d_fall[i]  = fall_q;
    assign d_edge[i]  = rise_q | fall_q;

`ifdef EDGE_CNT_EN
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    // Clear wins over a coincident pulse; the count sticks at all-ones.
    always_comb begin
      ecnt_d = ecnt_q;
      if (cnt_clr) begin
        ecnt_d = '0;
      end else if ((rise_q | fall_q) && (ecnt_q != {CNT_W{1'b1}})) begin
        ecnt_d = ecnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ecnt_q <= '0;
      end else begin
        ecnt_q <= ecnt_d;
      end
    end

    assign edge_cnt[CNT_W*i +: CNT_W] = ecnt_q;
`else
    assign edge_cnt[CNT_W*i +: CNT_W] = '0;
`endif
  end

`ifndef EDGE_CNT_EN
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: two instances (FILT_LEN=1 and FILT_LEN=4) driven in
// parallel and checked against a sample-history reference model plus directed checks.
module tb_edge_detect_multi;

  localparam int SYNC = 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  d_in;
  logic [3:0]  mode;
  logic        cnt_clr;

  logic [1:0]  l0, r0, f0, e0;
  logic [15:0] c0;
  logic [1:0]  l1, r1, f1, e1;
  logic [15:0] c1;

  int total = 0;
  int bad   = 0;

  edge_detect_multi #(
    .NUM_CH(2), .SYNC_STAGES(SYNC), .FILT_LEN(1), .IDLE_VAL(1), .CNT_W(8)
  ) u_dut_f1 (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .mode(mode),
    .d_level(l0), .d_rise(r0), .d_fall(f0), .d_edge(e0),
    .cnt_clr(cnt_clr), .edge_cnt(c0)
  );

  edge_detect_multi #(
    .NUM_CH(2), .SYNC_STAGES(SYNC), .FILT_LEN(4), .IDLE_VAL(1), .CNT_W(8)
  ) u_dut_f4 (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .mode(mode),
    .d_level(l1), .d_rise(r1), .d_fall(f1), .d_edge(e1),
    .cnt_clr(cnt_clr), .edge_cnt(c1)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a level flips once the delayed input has shown the opposite
  // value on FILT_LEN consecutive clock edges; counters count emitted pulses.
  logic [1:0] hist[$];
  logic [1:0] m_level[2] = '{2'b11, 2'b11};
  logic [1:0] m_rise[2]  = '{2'b00, 2'b00};
  logic [1:0] m_fall[2]  = '{2'b00, 2'b00};
  int         m_cnt[2][2];

  initial begin
    int  idx;
    int  flen;
    logic want, ok, v;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        hist.delete();
        for (int d = 0; d < 2; d++) begin
          m_level[d] = 2'b11;
          m_rise[d]  = 2'b00;
          m_fall[d]  = 2'b00;
          m_cnt[d][0] = 0;
          m_cnt[d][1] = 0;
        end
      end else begin
        hist.push_back(d_in);
        if (hist.size() > 12) void'(hist.pop_front());
        for (int d = 0; d < 2; d++) begin
          flen = (d == 0) ? 1 : 4;
          for (int ch = 0; ch < 2; ch++) begin
`ifdef EDGE_CNT_EN
            if (cnt_clr) m_cnt[d][ch] = 0;
            else if ((m_rise[d][ch] | m_fall[d][ch]) && m_cnt[d][ch] < 255) m_cnt[d][ch]++;
`endif
            want = ~m_level[d][ch];
            ok = 1'b1;
            for (int j = 0; j < flen; j++) begin
              idx = hist.size() - 1 - SYNC - j;
              v = (idx < 0) ? 1'b1 : hist[idx][ch];
              if (v != want) ok = 1'b0;
            end
            m_rise[d][ch] = ok & want & en & mode[2*ch];
            m_fall[d][ch] = ok & ~want & en & mode[2*ch+1];
            if (ok) m_level[d][ch] = want;
          end
        end
      end
    end
  end

  logic [47:0] obs, expv;
  assign obs = {l0, r0, f0, e0, c0, l1, r1, f1, e1, c1};
  always @* begin
    expv = {m_level[0], m_rise[0], m_fall[0], m_rise[0] | m_fall[0],
            8'(m_cnt[0][1]), 8'(m_cnt[0][0]),
            m_level[1], m_rise[1], m_fall[1], m_rise[1] | m_fall[1],
            8'(m_cnt[1][1]), 8'(m_cnt[1][0])};
  end

  // Driver tasks
  task automatic test_reset();
    int nf0_0, nf0_1, nf1_0, nf1_1;
    nf0_0 = 0; nf0_1 = 0; nf1_0 = 0; nf1_1 = 0;
    rst = 1'b1; d_in = 2'b00; mode = 4'b1111; en = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({l0, l1, e0, e1} !== 8'b1111_0000) begin
      bad++; $display("FAIL reset_state got=%b exp=%b", {l0, l1, e0, e1}, 8'b1111_0000);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", c, obs, expv); end
      if (c < 2) begin
        total++;
        if ({l0, e0} !== 4'b1100) begin
          bad++; $display("FAIL reset_release cyc=%0d got=%b exp=1100", c, {l0, e0});
        end
      end
      nf0_0 += int'(f0[0]); nf0_1 += int'(f0[1]); nf1_0 += int'(f1[0]); nf1_1 += int'(f1[1]);
    end
    total++;
    if ({nf0_0, nf0_1, nf1_0, nf1_1} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      bad++; $display("FAIL reset_fall_count got=%0d,%0d,%0d,%0d exp=1,1,1,1", nf0_0, nf0_1, nf1_0, nf1_1);
    end
    total++;
    if ({l0, l1} !== 4'b0000) begin bad++; $display("FAIL reset_settle got=%b exp=0000", {l0, l1}); end
  endtask

  task automatic test_rise_latency();
    mode = 4'b0101;
    d_in = 2'b01;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL latency_model cyc=%0d got=%h exp=%h", c, obs, expv); end
      total++;
      if ({r0[0], r1[0], f0, e0[1]} !== {(c == 2), (c == 5), 3'b000}) begin
        bad++; $display("FAIL latency cyc=%0d got=%b exp=%b", c, {r0[0], r1[0], f0, e0[1]}, {(c == 2), (c == 5), 3'b000});
      end
    end
  endtask

  task automatic test_glitch();
    int nr, nf;
    logic seen_high;
    mode = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      d_in = (c < 3) ? 2'b11 : 2'b01;
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", c, obs, expv); end
      total++;
      if ({l1[1], r1[1]} !== 2'b00) begin
        bad++; $display("FAIL glitch_reject cyc=%0d got=%b exp=00", c, {l1[1], r1[1]});
      end
    end
    nr = 0; nf = 0; seen_high = 1'b0;
    for (int c = 0; c < 18; c++) begin
      d_in = (c < 4) ? 2'b11 : 2'b01;
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL glitch4_model cyc=%0d got=%h exp=%h", c, obs, expv); end
      nr += int'(r1[1]); nf += int'(f1[1]);
      if (l1[1]) seen_high = 1'b1;
    end
    total++;
    if (nr !== 1 || nf !== 1 || seen_high !== 1'b1) begin
      bad++; $display("FAIL glitch_accept got=rise%0d fall%0d high%b exp=rise1 fall1 high1", nr, nf, seen_high);
    end
  endtask

  task automatic test_mode_en();
    mode = 4'b1101;
    d_in = 2'b00;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL mode_model cyc=%0d got=%h exp=%h", c, obs, expv); end
      total++;
      if ({f0[0], f1[0]} !== 2'b00) begin bad++; $display("FAIL mode_gate cyc=%0d got=%b exp=00", c, {f0[0], f1[0]}); end
    end
    total++;
    if ({l0[0], l1[0]} !== 2'b00) begin bad++; $display("FAIL mode_level got=%b exp=00", {l0[0], l1[0]}); end
    en = 1'b0; mode = 4'b1111; d_in = 2'b01;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL en_model cyc=%0d got=%h exp=%h", c, obs, expv); end
      total++;
      if ({e0, e1} !== 4'b0000) begin bad++; $display("FAIL en_gate cyc=%0d got=%b exp=0000", c, {e0, e1}); end
    end
    total++;
    if ({l0[0], l1[0]} !== 2'b11) begin bad++; $display("FAIL en_level got=%b exp=11", {l0[0], l1[0]}); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    mode = 4'b1111;
    d_in = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", c, obs, expv); end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({l0, l1, e0, e1, c0, c1} !== {8'b1111_0000, 32'h0}) begin
      bad++; $display("FAIL rstmid_async got=%b exp=11110000", {l0, l1, e0, e1});
    end
    @(negedge clk);
    d_in = 2'b11;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL rstmid_release_model cyc=%0d got=%h exp=%h", c, obs, expv); end
      total++;
      if ({l0, l1, e0, e1} !== 8'b1111_0000) begin
        bad++; $display("FAIL rstmid_release cyc=%0d got=%b exp=11110000", c, {l0, l1, e0, e1});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int ch = 0; ch < 2; ch++)
        if ($urandom_range(0, 4) == 0) d_in[ch] = ~d_in[ch];
      if (c % 50 == 0) mode = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) != 0);
      cnt_clr = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, obs, expv); end
    end
    en = 1'b1; cnt_clr = 1'b0; mode = 4'b1111;
  endtask

  task automatic test_counter();
    logic hit;
    cnt_clr = 1'b1;
    repeat (8) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL cnt_settle_model got=%h exp=%h", obs, expv); end
      cnt_clr = 1'b0;
    end
    for (int n = 0; n < 3; n++) begin
      d_in[0] = ~d_in[0];
      repeat (4) begin
        @(negedge clk);
        total++;
        if (obs !== expv) begin bad++; $display("FAIL cnt_pre_model got=%h exp=%h", obs, expv); end
      end
    end
    d_in[0] = ~d_in[0];
    hit = 1'b0;
    for (int c = 0; c < 6 && !hit; c++) begin
      @(negedge clk);
      if (e0[0]) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL cnt_edge_wait got=no_pulse exp=pulse");
    end else begin
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      total++;
      if (c0[7:0] !== 8'h00) begin bad++; $display("FAIL cnt_clr_priority got=%h exp=00", c0[7:0]); end
      total++;
      if (obs !== expv) begin bad++; $display("FAIL cnt_clr_model got=%h exp=%h", obs, expv); end
    end
    for (int n = 0; n < 300; n++) begin
      d_in[0] = ~d_in[0];
      repeat (2) begin
        @(negedge clk);
        total++;
        if (obs !== expv) begin bad++; $display("FAIL cnt_sat_model n=%0d got=%h exp=%h", n, obs, expv); end
      end
    end
    repeat (4) @(negedge clk);
    total++;
`ifdef EDGE_CNT_EN
    if (c0[7:0] !== 8'hFF) begin bad++; $display("FAIL cnt_saturate got=%h exp=ff", c0[7:0]); end
`else
    if (c0[7:0] !== 8'h00) begin bad++; $display("FAIL cnt_absent got=%h exp=00", c0[7:0]); end
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; d_in = 2'b00; mode = 4'b1111; cnt_clr = 1'b0;
    test_reset();
    test_rise_latency();
    test_glitch();
    test_mode_en();
    test_reset_mid();
    test_random();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    total++;
    bad++;
    $display("FAIL watchdog got=timeout exp=completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
